// File: rtl/add_seq_64.sv
// ---------------------------------------------------------------------------
// add_seq_64 -- multi-cycle wide adder/subtractor built around one 16-bit
// carry-lookahead slice (add_pg_16).
//
// The operands are latched when start is accepted. The design then makes one
// pass through add_pg_16 per clock, going from the LSB slice to the MSB slice.
// The slice carry is registered between passes. The full result, carry-out
// and signed overflow are published together with a one-cycle done pulse.
//
// Ports (add_seq_64):
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request; accepted only while busy=0
//   sub        sampled with start; 1 = val1 - val2
//   val1       operand A, sampled with start
//   val2       operand B, sampled with start
//   carry_in   sampled with start; ignored when sub=1
//   busy       operation in progress
//   done       one-cycle pulse; val_out/carry_out/overflow are valid
//   val_out    result; holds until the next completion
//   carry_out  carry out of bit WIDTH-1 (for sub, 1 = no borrow)
//   overflow   signed two's-complement overflow
//
// Ports (add_pg_16):
//   a, b       16-bit addends
//   carry_in   carry into bit 0
//   sum        16-bit sum
//   carry_out  carry out of bit 15
//   prop_out   group propagate (all 16 bits propagate)
//   gen_out    group generate (carry out with carry_in=0)
// ---------------------------------------------------------------------------

module add_pg_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out,
    output logic        prop_out,
    output logic        gen_out
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [4:0]  grp_c;
    logic [15:0] bit_c;

    assign p = a ^ b;
    assign g = a & b;

    // Two-level lookahead: 4-bit groups produce group P/G, the group carries
    // are resolved from those, and each group then forms its own bit carries.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        grp_c = '0;
        bit_c = '0;
        for (int j = 0; j < 4; j++) begin
            grp_p[j] = &p[4*j +: 4];
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        grp_c[0] = carry_in;
        for (int j = 0; j < 4; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        for (int j = 0; j < 4; j++) begin
            bit_c[4*j] = grp_c[j];
            for (int i = 1; i < 4; i++) begin
                bit_c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & bit_c[4*j+i-1]);
            end
        end
    end

    assign sum       = p ^ bit_c;
    assign carry_out = grp_c[4];
    assign prop_out  = &grp_p;
    assign gen_out   = grp_g[3]
                     | (grp_p[3] & grp_g[2])
                     | (grp_p[3] & grp_p[2] & grp_g[1])
                     | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

endmodule

module add_seq_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] val_out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NUM_SLICES = WIDTH / 16;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    generate
        if ((WIDTH % 16) != 0 || WIDTH < 16) begin : g_width_check
            $error("add_seq_64: WIDTH must be a multiple of 16 and >= 16");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state_reg;
    logic [IDX_W-1:0]             idx_reg;
    logic                         carry_reg;
    logic [NUM_SLICES-1:0][15:0]  a_reg;
    logic [NUM_SLICES-1:0][15:0]  b_reg;      // already inverted for sub
    logic [NUM_SLICES-1:0][15:0]  acc_reg;    // partial sums, never visible
    logic [NUM_SLICES-1:0][15:0]  acc_next;
    logic                         busy_reg;
    logic                         done_reg;
    logic [WIDTH-1:0]             val_out_reg;
    logic                         carry_out_reg;
    logic                         overflow_reg;

    logic [15:0]                  slice_a;
    logic [15:0]                  slice_b;
    logic [15:0]                  slice_sum;
    logic                         slice_cout;
    logic                         unused_prop;
    logic                         unused_gen;
    logic                         last_slice;
    logic                         a_msb;
    logic                         b_msb;

    // Operand slice selection; a single-slice build has nothing to index.
    generate
        if (NUM_SLICES == 1) begin : g_one_slice
            assign slice_a = a_reg[0];
            assign slice_b = b_reg[0];
        end else begin : g_multi_slice
            assign slice_a = a_reg[idx_reg];
            assign slice_b = b_reg[idx_reg];
        end
    endgenerate

    add_pg_16 u_slice (
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (carry_reg),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .prop_out  (unused_prop),
        .gen_out   (unused_gen)
    );

    // Accumulator with the current slice merged in. On the last pass this is
    // the complete result, so it feeds val_out directly at completion.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_acc
            assign acc_next[gi] = (idx_reg == IDX_W'(gi)) ? slice_sum : acc_reg[gi];
        end
    endgenerate

    assign last_slice = (idx_reg == LAST_IDX);
    assign a_msb      = a_reg[NUM_SLICES-1][15];
    assign b_msb      = b_reg[NUM_SLICES-1][15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            val_out_reg   <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= val1;
                        b_reg     <= sub ? ~val2 : val2;
                        // Subtraction is A + ~B + 1, so the +1 enters as carry.
                        carry_reg <= sub | carry_in;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        val_out_reg   <= acc_next;
                        carry_out_reg <= slice_cout;
                        overflow_reg  <= (a_msb == b_msb) && (slice_sum[15] != a_msb);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign val_out   = val_out_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_add_seq_64.sv
// Bench for add_seq_64: one 64-bit and one 16-bit instance, directed cases
// with literal expectations plus randomized traffic against an arithmetic
// reference model.
module tb_add_seq_64;

    logic        clk;
    logic        rst;

    logic        s64_start, s64_sub, s64_cin;
    logic [63:0] s64_v1, s64_v2;
    logic        b64, d64, c64, o64;
    logic [63:0] v64;

    logic        s16_start, s16_sub, s16_cin;
    logic [15:0] s16_v1, s16_v2;
    logic        b16, d16, c16, o16;
    logic [15:0] v16;

    int checks = 0;
    int errors = 0;

    add_seq_64 #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .start(s64_start), .sub(s64_sub),
        .val1(s64_v1), .val2(s64_v2), .carry_in(s64_cin),
        .busy(b64), .done(d64), .val_out(v64), .carry_out(c64), .overflow(o64)
    );

    add_seq_64 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .sub(s16_sub),
        .val1(s16_v1), .val2(s16_v2), .carry_in(s16_cin),
        .busy(b16), .done(d16), .val_out(v16), .carry_out(c16), .overflow(o16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] val;
        logic        co;
        logic        ov;
    } res_t;

    // Plain arithmetic: subtraction is a true difference with carry = no borrow.
    function automatic res_t ref_op(input int w, input logic sb,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic cin);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        res_t r;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (!sb) begin
            full = {1'b0, a} + {1'b0, b} + 65'(cin);
            r.co = full[w];
        end else begin
            full = {1'b0, a} - {1'b0, b};
            r.co = (a >= b);
        end
        r.val = full[63:0] & mask;
        if (!sb) r.ov = (a[w-1] == b[w-1]) && (r.val[w-1] != a[w-1]);
        else     r.ov = (a[w-1] != b[w-1]) && (r.val[w-1] != a[w-1]);
        return r;
    endfunction

    logic        in_start [2];
    logic        in_sub   [2];
    logic        in_cin   [2];
    logic [63:0] in_a     [2];
    logic [63:0] in_b     [2];
    assign in_start[0] = s64_start;  assign in_start[1] = s16_start;
    assign in_sub[0]   = s64_sub;    assign in_sub[1]   = s16_sub;
    assign in_cin[0]   = s64_cin;    assign in_cin[1]   = s16_cin;
    assign in_a[0]     = s64_v1;     assign in_a[1]     = {48'd0, s16_v1};
    assign in_b[0]     = s64_v2;     assign in_b[1]     = {48'd0, s16_v2};

    int   m_cnt  [2];
    logic m_done [2];
    res_t m_pend [2];
    res_t m_out  [2];
    logic model_ready = 1'b0;

    // Model: an accepted request completes NUM_SLICES edges later; requests
    // while an operation is pending are dropped.
    always @(posedge clk or posedge rst) begin
        model_ready <= 1'b1;
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                m_cnt[l]  <= 0;
                m_done[l] <= 1'b0;
                m_out[l]  <= '0;
                m_pend[l] <= '0;
            end else begin
                m_done[l] <= 1'b0;
                if (m_cnt[l] != 0) begin
                    m_cnt[l] <= m_cnt[l] - 1;
                    if (m_cnt[l] == 1) begin
                        m_done[l] <= 1'b1;
                        m_out[l]  <= m_pend[l];
                    end
                end else if (in_start[l]) begin
                    m_pend[l] <= ref_op((l == 0) ? 64 : 16, in_sub[l], in_a[l], in_b[l], in_cin[l]);
                    m_cnt[l]  <= (l == 0) ? 4 : 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            check("m64 busy", 64'(b64), 64'(m_cnt[0] != 0));
            check("m64 done", 64'(d64), 64'(m_done[0]));
            check("m64 val",  v64,      m_out[0].val);
            check("m64 cout", 64'(c64), 64'(m_out[0].co));
            check("m64 ovf",  64'(o64), 64'(m_out[0].ov));
            check("m16 busy", 64'(b16), 64'(m_cnt[1] != 0));
            check("m16 done", 64'(d16), 64'(m_done[1]));
            check("m16 val",  64'(v16), m_out[1].val);
            check("m16 cout", 64'(c16), 64'(m_out[1].co));
            check("m16 ovf",  64'(o16), 64'(m_out[1].ov));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic w16, input logic st, input logic sb,
                         input logic [63:0] a, input logic [63:0] b, input logic c);
        if (w16) begin
            s16_start = st; s16_sub = sb; s16_v1 = a[15:0]; s16_v2 = b[15:0]; s16_cin = c;
        end else begin
            s64_start = st; s64_sub = sb; s64_v1 = a; s64_v2 = b; s64_cin = c;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick_val();
        int sel;
        logic [63:0] r;
        sel = $urandom_range(0, 5);
        case (sel)
            0: r = 64'd0;
            1: r = 64'hFFFF_FFFF_FFFF_FFFF;
            2: r = 64'h8000_0000_0000_8000;
            3: r = 64'h7FFF_FFFF_FFFF_7FFF;
            default: r = rnd64();
        endcase
        return r;
    endfunction

    // Issue one operation and wait (bounded) for done, checking latency,
    // busy length and, when asked, literal results. poke>0 pulses start with
    // fresh operands for one cycle that many edges into the operation.
    task automatic run_op(input logic w16, input string name, input logic sb,
                          input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input int poke, input logic chk_lit,
                          input logic [63:0] ev, input logic ec, input logic eo);
        int   edges;
        int   bc;
        int   lat;
        logic got;
        lat = w16 ? 1 : 4;
        @(negedge clk);
        drive(w16, 1'b1, sb, a, b, cin);
        @(posedge clk);
        #1;
        drive(w16, 1'b0, $urandom_range(0, 1), rnd64(), rnd64(), $urandom_range(0, 1));
        edges = 0;
        got   = 1'b0;
        bc    = (w16 ? b16 : b64) ? 1 : 0;
        while (edges < 20 && !got) begin
            @(posedge clk);
            edges++;
            #1;
            if (w16 ? d16 : d64) begin
                got = 1'b1;
            end else begin
                if (w16 ? b16 : b64) bc++;
                if (poke != 0 && edges == poke)
                    drive(w16, 1'b1, $urandom_range(0, 1), rnd64(), rnd64(), 1'b0);
                else if (poke != 0 && edges == poke + 1)
                    drive(w16, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
            end
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " latency"},   64'(edges), 64'(lat));
        check({name, " busy len"},  64'(bc), 64'(lat));
        check({name, " busy at done"}, 64'(w16 ? b16 : b64), 64'd0);
        if (chk_lit) begin
            check({name, " val"},  w16 ? 64'(v16) : v64, ev);
            check({name, " cout"}, 64'(w16 ? c16 : c64), 64'(ec));
            check({name, " ovf"},  64'(w16 ? o16 : o64), 64'(eo));
        end
        $display("op %s: sub=%0d a=%h b=%h cin=%0d -> val=%h cout=%0d ovf=%0d after %0d edges",
                 name, sb, a, b, cin, w16 ? 64'(v16) : v64,
                 w16 ? c16 : c64, w16 ? o16 : o64, edges);
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (d64) n++;
        end
        check(name, 64'(n), 64'd0);
    endtask

    res_t pin;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);

        // Hand-computed pins on the model itself.
        pin = ref_op(64, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("model max+1", {pin.val[62:0], pin.co}, 64'd1);
        pin = ref_op(64, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        check("model min-1", pin.val, 64'h7FFF_FFFF_FFFF_FFFF);
        check("model min-1 flags", 64'({pin.co, pin.ov}), 64'd3);
        pin = ref_op(16, 1'b0, 64'hFFFF, 64'd1, 1'b1);
        check("model 16 wrap", {pin.val[62:0], pin.co}, 64'h3);

        repeat (3) @(posedge clk);
        #1;
        check("reset busy64", 64'(b64), 64'd0);
        check("reset done64", 64'(d64), 64'd0);
        check("reset val64",  v64, 64'd0);
        check("reset flags64", 64'({c64, o64}), 64'd0);
        check("reset busy16", 64'(b16), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, "64 max+1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b1, 64'd0, 1'b1, 1'b0);
        run_op(1'b0, "64 xslice", 1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 0, 1'b1, 64'h0000_0000_0001_0001, 1'b0, 1'b0);
        run_op(1'b0, "64 0-1", 1'b1, 64'd0, 64'd1, 1'b1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b0, "64 min-1", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_op(1'b0, "64 max+1 signed", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Start while busy must be ignored.
        run_op(1'b0, "64 poke", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 2, 1'b1,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
        expect_no_done("no extra done", 6);

        // Back-to-back: the second request is raised during the done cycle.
        run_op(1'b0, "64 b2b first", 1'b0, 64'd1, 64'd1, 1'b0, 0, 1'b1, 64'd2, 1'b0, 1'b0);
        check("b2b done still high", 64'(d64), 64'd1);
        run_op(1'b0, "64 5+7", 1'b0, 64'd5, 64'd7, 1'b0, 0, 1'b1, 64'd12, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(b64), 64'd0);
        check("midrst done", 64'(d64), 64'd0);
        check("midrst val",  v64, 64'd0);
        $display("midrst: busy=%0d done=%0d val=%h", b64, d64, v64);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("no done after rst", 6);
        run_op(1'b0, "64 3+4", 1'b0, 64'd3, 64'd4, 1'b0, 0, 1'b1, 64'd7, 1'b0, 1'b0);

        // 16-bit instance: single-pass latency.
        run_op(1'b1, "16 max+1", 1'b0, 64'hFFFF, 64'd1, 1'b0, 0, 1'b1, 64'd0, 1'b1, 1'b0);
        run_op(1'b1, "16 xslice", 1'b0, 64'hFFFF, 64'd1, 1'b1, 0, 1'b1, 64'h0001, 1'b1, 1'b0);
        run_op(1'b1, "16 0-1", 1'b1, 64'd0, 64'd1, 1'b1, 0, 1'b1, 64'hFFFF, 1'b0, 1'b0);
        run_op(1'b1, "16 min-1", 1'b1, 64'h8000, 64'd1, 1'b1, 0, 1'b1, 64'h7FFF, 1'b1, 1'b1);

        // Randomized traffic on both instances, including starts while busy.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1), pick_val(), pick_val(), $urandom_range(0, 1));
            drive(1'b1, $urandom_range(0, 2) == 0, $urandom_range(0, 1), pick_val(), pick_val(), $urandom_range(0, 1));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
